// File: rtl/sram_sched_pkg.sv
// Shared defaults and state encoding for the sram_rw_sched scheduler.
package sram_sched_pkg;

    function automatic int unsigned addr_bits(input int unsigned depth);
        return $clog2(depth);
    endfunction

    localparam int unsigned DEPTH_DEF        = 512;
    localparam int unsigned ADDR_W_DEF       = addr_bits(DEPTH_DEF);
    localparam int unsigned DATA_W_DEF       = 80;
    localparam int unsigned MASK_W_DEF       = 8;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } sched_state_e;

endpackage

// File: rtl/sram_sched_wbuf.sv
// One-entry write buffer with starvation counter and read/write address comparator.
module sram_sched_wbuf #(
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned DATA_W       = 80,
    parameter int unsigned MASK_W       = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              issue,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [MASK_W-1:0] w_mask,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_valid,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              wbuf_valid,
    output logic [ADDR_W-1:0] wbuf_addr,
    output logic [MASK_W-1:0] wbuf_mask,
    output logic [DATA_W-1:0] wbuf_data,
    output logic              force_w
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbuf_valid <= 1'b0;
            wbuf_addr  <= '0;
            wbuf_mask  <= '0;
            wbuf_data  <= '0;
            starve_cnt <= '0;
        end else begin
            // A load on the draining edge refills the entry in place.
            if (load) begin
                wbuf_valid <= 1'b1;
                wbuf_addr  <= w_addr;
                wbuf_mask  <= w_mask;
                wbuf_data  <= w_data;
            end else if (issue) begin
                wbuf_valid <= 1'b0;
            end

            if (issue || !wbuf_valid) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        force_w = wbuf_valid & ((starve_cnt == LIMIT) | (r_valid & (r_addr == wbuf_addr)));
    end

endmodule

// File: rtl/sram_rw_sched.sv
// Single-port SRAM scheduler sharing one masked-write array between a reader and a writer.
// Define SRAM_SCHED_INIT_EN to zero the array with a post-reset sweep before READY.
module sram_rw_sched
    import sram_sched_pkg::*;
#(
    parameter int unsigned DEPTH        = DEPTH_DEF,
    parameter int unsigned ADDR_W       = addr_bits(DEPTH),
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned MASK_W       = MASK_W_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r_req_valid,
    output logic              r_req_ready,
    input  logic [ADDR_W-1:0] r_req_addr,
    output logic              r_resp_valid,
    output logic [DATA_W-1:0] r_resp_data,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic [ADDR_W-1:0] w_req_addr,
    input  logic [MASK_W-1:0] w_req_mask,
    input  logic [DATA_W-1:0] w_req_data,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    sched_state_e state_q, state_d;

    logic              read_fire;
    logic              wbuf_issue;
    logic              wbuf_load;
    logic              wbuf_valid;
    logic              force_w;
    logic [ADDR_W-1:0] wbuf_addr;
    logic [MASK_W-1:0] wbuf_mask;
    logic [DATA_W-1:0] wbuf_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            r_resp_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_resp_valid <= read_fire;
        end
    end

`ifdef SRAM_SCHED_INIT_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] sweep_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_addr <= '0;
        end else if (state_q == INIT) begin
            sweep_addr <= sweep_addr + ADDR_W'(1);
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        r_req_ready = 1'b0;
        read_fire  = 1'b0;
        wbuf_issue = 1'b0;
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;

        case (state_q)
            INIT: begin
`ifdef SRAM_SCHED_INIT_EN
                // Reset resets state to INIT, so gate the sweep port to keep outputs low in reset.
                if (rst_n) begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_addr  = sweep_addr;
                    sram_wmask = '1;
                end
                if (sweep_addr == LAST_ADDR) begin
                    state_d = READY;
                end
`else
                state_d = READY;
`endif
            end
            READY: begin
                r_req_ready = !force_w;
                read_fire   = r_req_valid & !force_w;
                if (read_fire) begin
                    sram_en   = 1'b1;
                    sram_addr = r_req_addr;
                end else if (wbuf_valid) begin
                    wbuf_issue = 1'b1;
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_addr  = wbuf_addr;
                    sram_wmask = wbuf_mask;
                    sram_wdata = wbuf_data;
                end
            end
            default: state_d = INIT;
        endcase

        w_req_ready = (state_q == READY) & (!wbuf_valid | wbuf_issue);
        wbuf_load   = w_req_valid & w_req_ready;
    end

    assign init_done   = (state_q == READY);
    assign r_resp_data = r_resp_valid ? sram_rdata : '0;

    sram_sched_wbuf #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MASK_W       (MASK_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_wbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (wbuf_load),
        .issue      (wbuf_issue),
        .w_addr     (w_req_addr),
        .w_mask     (w_req_mask),
        .w_data     (w_req_data),
        .r_valid    (r_req_valid),
        .r_addr     (r_req_addr),
        .wbuf_valid (wbuf_valid),
        .wbuf_addr  (wbuf_addr),
        .wbuf_mask  (wbuf_mask),
        .wbuf_data  (wbuf_data),
        .force_w    (force_w)
    );

endmodule

// File: tb/tb_sram_rw_sched.sv
// Scoreboard bench for sram_rw_sched: expected SRAM ops and read responses are queued by
// the stimulus and popped by a negedge monitor. Honours SRAM_SCHED_INIT_EN.
module tb_sram_rw_sched;
    import sram_sched_pkg::*;

    localparam int unsigned AW = ADDR_W_DEF;
    localparam int unsigned DW = DATA_W_DEF;
    localparam int unsigned MW = MASK_W_DEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r_req_valid = 1'b0;
    logic          r_req_ready;
    logic [AW-1:0] r_req_addr = '0;
    logic          r_resp_valid;
    logic [DW-1:0] r_resp_data;
    logic          w_req_valid = 1'b0;
    logic          w_req_ready;
    logic [AW-1:0] w_req_addr = '0;
    logic [MW-1:0] w_req_mask = '0;
    logic [DW-1:0] w_req_data = '0;
    logic          init_done;
    logic          sram_en;
    logic          sram_wmode;
    logic [AW-1:0] sram_addr;
    logic [MW-1:0] sram_wmask;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;

    sram_rw_sched #(
        .DEPTH        (512),
        .DATA_W       (80),
        .MASK_W       (8),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .r_req_valid  (r_req_valid),
        .r_req_ready  (r_req_ready),
        .r_req_addr   (r_req_addr),
        .r_resp_valid (r_resp_valid),
        .r_resp_data  (r_resp_data),
        .w_req_valid  (w_req_valid),
        .w_req_ready  (w_req_ready),
        .w_req_addr   (w_req_addr),
        .w_req_mask   (w_req_mask),
        .w_req_data   (w_req_data),
        .init_done    (init_done),
        .sram_en      (sram_en),
        .sram_wmode   (sram_wmode),
        .sram_addr    (sram_addr),
        .sram_wmask   (sram_wmask),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle = cycle + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          wmode;
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
        logic [DW-1:0] data;
        int            cyc;
    } op_t;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } resp_t;

    op_t   op_q[$];
    resp_t resp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Behavioural model of the 512x80 array, 10-bit granules, 1-cycle read latency.
    logic [DW-1:0] mem [512];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int g = 0; g < 8; g++) begin
            if (m[g]) r[g*10 +: 10] = d[g*10 +: 10];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (sram_en === 1'b1) begin
            if (sram_wmode) mem[sram_addr] <= merge(mem[sram_addr], sram_wdata, sram_wmask);
            else            sram_rdata <= mem[sram_addr];
        end
    end

    op_t   mon_op;
    resp_t mon_resp;

    always @(negedge clk) begin
        if (sram_en === 1'b1) begin
            if (op_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sram_op: got op wmode=%0b addr=%0h at cycle %0d expected none",
                         sram_wmode, sram_addr, cycle);
            end else begin
                mon_op = op_q.pop_front();
                check("op_cycle", 128'(cycle), 128'(mon_op.cyc));
                check("op_wmode", 128'(sram_wmode), 128'(mon_op.wmode));
                check("op_addr", 128'(sram_addr), 128'(mon_op.addr));
                if (mon_op.wmode) begin
                    check("op_wmask", 128'(sram_wmask), 128'(mon_op.mask));
                    check("op_wdata", 128'(sram_wdata), 128'(mon_op.data));
                end
            end
        end
        if (r_resp_valid === 1'b1) begin
            if (resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL r_resp: got data %0h at cycle %0d expected no response",
                         r_resp_data, cycle);
            end else begin
                mon_resp = resp_q.pop_front();
                check("resp_cycle", 128'(cycle), 128'(mon_resp.cyc));
                check("resp_data", 128'(r_resp_data), 128'(mon_resp.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic wm, input logic [AW-1:0] a, input logic [MW-1:0] m,
                           input logic [DW-1:0] d, input int c);
        op_t o;
        o.wmode = wm; o.addr = a; o.mask = m; o.data = d; o.cyc = c;
        op_q.push_back(o);
    endtask

    task automatic push_resp(input logic [DW-1:0] d, input int c);
        resp_t r;
        r.data = d; r.cyc = c;
        resp_q.push_back(r);
    endtask

    task automatic do_reset();
        int c0;
        rst_n       = 1'b0;
        r_req_valid = 1'b0;
        w_req_valid = 1'b0;
        @(negedge clk);
        check("reset_ctrl", 128'({init_done, r_req_ready, w_req_ready, r_resp_valid,
                                  sram_en, sram_wmode, sram_addr, sram_wmask}), '0);
        check("reset_wdata", 128'(sram_wdata), '0);
        check("reset_rdata", 128'(r_resp_data), '0);
        tick();
        tick();
        rst_n = 1'b1;
        c0 = cycle;
`ifdef SRAM_SCHED_INIT_EN
        for (int i = 0; i < 512; i++) push_op(1'b1, AW'(i), '1, '0, c0 + i);
        @(negedge clk);
        check("init_done_start", 128'(init_done), 128'(0));
        repeat (511) tick();
        @(negedge clk);
        check("init_done_511", 128'(init_done), 128'(0));
        tick();
        @(negedge clk);
        check("init_done_512", 128'(init_done), 128'(1));
`else
        @(negedge clk);
        check("init_done_start", 128'(init_done), 128'(0));
        tick();
        @(negedge clk);
        check("init_done_first", 128'(init_done), 128'(1));
`endif
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
        tick();
        w_req_valid = 1'b1;
        w_req_addr  = a;
        w_req_mask  = m;
        w_req_data  = d;
        push_op(1'b1, a, m, d, cycle + 1);
        @(negedge clk);
        check("w_req_ready", 128'(w_req_ready), 128'(1));
        tick();
        w_req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        tick();
        r_req_valid = 1'b1;
        r_req_addr  = a;
        push_op(1'b0, a, '0, '0, cycle);
        push_resp(exp, cycle + 1);
        @(negedge clk);
        check("r_req_ready", 128'(r_req_ready), 128'(1));
        tick();
        r_req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    localparam logic [DW-1:0] ALL_ONES  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [DW-1:0] D_STARVE  = 80'h0123_4567_89AB_CDEF_0F1E;
    localparam logic [DW-1:0] D_HAZARD  = 80'h1234_5678_9ABC_DEF0_1357;
    localparam logic [6:0]    STARVE_RR = 7'b1011111;  // bit k = cycle k
    localparam logic [6:0]    STARVE_WR = 7'b1100001;

    initial begin
        int c;
        for (int i = 0; i < 512; i++) begin
`ifdef SRAM_SCHED_INIT_EN
            mem[i] = 80'hA5A5_A5A5_A5A5_A5A5_A5A5;
`else
            mem[i] = '0;
`endif
        end

        tick();
        do_reset();

`ifdef SRAM_SCHED_INIT_EN
        do_read(9'h000, '0);
        do_read(9'h1FF, '0);
`endif

        // Masked writes: one granule, then the two end granules of an all-ones word.
        do_write(9'h010, 8'h01, 80'h3FF);
        do_read(9'h010, 80'h3FF);
        do_write(9'h011, 8'h81, ALL_ONES);
        do_read(9'h011, 80'hFFC0_0000_0000_0000_03FF);

        // Continuous reads starve a buffered write for exactly STARVE_LIMIT cycles.
        tick();
        r_req_valid = 1'b1;
        r_req_addr  = 9'h020;
        w_req_valid = 1'b1;
        w_req_addr  = 9'h030;
        w_req_mask  = 8'hFF;
        w_req_data  = D_STARVE;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick();
            if (k == 1) w_req_valid = 1'b0;
            if (STARVE_RR[k]) begin
                push_op(1'b0, 9'h020, '0, '0, cycle);
                push_resp('0, cycle + 1);
            end else begin
                push_op(1'b1, 9'h030, 8'hFF, D_STARVE, cycle);
            end
            @(negedge clk);
            check("starve_r_ready", 128'(r_req_ready), 128'(STARVE_RR[k]));
            check("starve_w_ready", 128'(w_req_ready), 128'(STARVE_WR[k]));
        end
        tick();
        r_req_valid = 1'b0;
        do_read(9'h030, D_STARVE);

        // Read-after-write to the buffered address: write first, read next cycle.
        tick();
        w_req_valid = 1'b1;
        w_req_addr  = 9'h055;
        w_req_mask  = 8'hFF;
        w_req_data  = D_HAZARD;
        c = cycle;
        @(negedge clk);
        check("hazard_w_ready", 128'(w_req_ready), 128'(1));
        tick();
        w_req_valid = 1'b0;
        r_req_valid = 1'b1;
        r_req_addr  = 9'h055;
        push_op(1'b1, 9'h055, 8'hFF, D_HAZARD, c + 1);
        @(negedge clk);
        check("hazard_r_blocked", 128'(r_req_ready), 128'(0));
        tick();
        push_op(1'b0, 9'h055, '0, '0, c + 2);
        push_resp(D_HAZARD, c + 3);
        @(negedge clk);
        check("hazard_r_ready", 128'(r_req_ready), 128'(1));
        tick();
        r_req_valid = 1'b0;

        // Back-to-back writes drain and refill the buffer on the same edge.
        tick();
        for (int j = 0; j < 3; j++) begin
            if (j > 0) tick();
            w_req_valid = 1'b1;
            w_req_addr  = AW'(j + 1);
            w_req_mask  = 8'hFF;
            w_req_data  = {8{10'(j + 1)}};
            push_op(1'b1, AW'(j + 1), 8'hFF, {8{10'(j + 1)}}, cycle + 1);
            @(negedge clk);
            check("b2b_w_ready", 128'(w_req_ready), 128'(1));
        end
        tick();
        w_req_valid = 1'b0;
        do_read(9'h002, {8{10'd2}});

        // Reset with a buffered write and a pending read response; both are dropped.
        tick();
        w_req_valid = 1'b1;
        w_req_addr  = 9'h077;
        w_req_mask  = 8'hFF;
        w_req_data  = ALL_ONES;
        r_req_valid = 1'b1;
        r_req_addr  = 9'h010;
        push_op(1'b0, 9'h010, '0, '0, cycle);
        @(negedge clk);
        check("midrst_r_ready", 128'(r_req_ready), 128'(1));
        check("midrst_w_ready", 128'(w_req_ready), 128'(1));
        tick();
        do_reset();
        do_read(9'h077, '0);

        repeat (3) tick();
        check("op_queue_empty", 128'(op_q.size()), 128'(0));
        check("resp_queue_empty", 128'(resp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
